// File: rtl/tz_pkg.sv
// Shared constants, types and helpers for the multi-zone world-clock converter.
package tz_pkg;

    localparam int MIN_PER_DAY  = 1440;
    localparam int MIN_PER_HOUR = 60;
    localparam int QTR_MIN      = 15;
    localparam int OFF_MIN      = -48;
    localparam int OFF_MAX      = 56;
    localparam int DST_QTR      = 4;
    localparam int ADD_OFF_W    = 8;

    localparam int DEF_OFF_0 = 4;
    localparam int DEF_OFF_1 = 12;
    localparam int DEF_OFF_2 = 24;
    localparam int DEF_OFF_3 = 36;

    typedef enum logic [1:0] {
        DaySame = 2'b00,
        DayNext = 2'b01,
        DayPrev = 2'b11
    } day_adj_t;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_t;

    function automatic int default_off(input int idx);
        case (idx)
            0:       return DEF_OFF_0;
            1:       return DEF_OFF_1;
            2:       return DEF_OFF_2;
            3:       return DEF_OFF_3;
            default: return 0;
        endcase
    endfunction

    function automatic int sat_off(input int off);
        if (off < OFF_MIN) return OFF_MIN;
        if (off > OFF_MAX) return OFF_MAX;
        return off;
    endfunction

endpackage

// File: rtl/tz_offset_add.sv
// Combinational local-time + quarter-hour offset adder with 24 h wrap and day carry/borrow.
module tz_offset_add
    import tz_pkg::*;
(
    input  logic        [5:0]           hour_i,
    input  logic        [5:0]           min_i,
    input  logic signed [ADD_OFF_W-1:0] off_i,
    output logic        [5:0]           hour_o,
    output logic        [5:0]           min_o,
    output day_adj_t                    day_o
);

    // 13 bits: 1439 min plus the largest DST-adjusted offset exceeds 12-bit signed range.
    localparam logic signed [12:0] DaySpan = 13'(MIN_PER_DAY);

    logic signed [12:0] t_raw;
    logic signed [12:0] t_wrap;
    logic        [10:0] t_pos;

    always_comb begin
        t_raw = 13'($signed({1'b0, hour_i})) * 13'(MIN_PER_HOUR)
              + 13'($signed({1'b0, min_i}))
              + 13'(off_i) * 13'(QTR_MIN);
        t_wrap = t_raw;
        day_o  = DaySame;
        if (t_raw >= DaySpan) begin
            t_wrap = t_raw - DaySpan;
            day_o  = DayNext;
        end else if (t_raw < 13'sd0) begin
            t_wrap = t_raw + DaySpan;
            day_o  = DayPrev;
        end
        t_pos  = 11'(t_wrap);
        hour_o = 6'(t_pos / 11'(MIN_PER_HOUR));
        min_o  = 6'(t_pos % 11'(MIN_PER_HOUR));
    end

endmodule

// File: rtl/tz_world_clock.sv
// Multi-zone world clock: scans a writable offset table through one shared adder per tick.
// Optional TZ_DST_EN adds a per-zone dst_mask input adding +1 h to flagged zones.
module tz_world_clock
    import tz_pkg::*;
#(
    parameter int unsigned NUM_ZONES = 4,
    parameter int unsigned OFF_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic [5:0]             hour_in,
    input  logic [5:0]             min_in,
    input  logic [NUM_ZONES-1:0]   zone_sel,
    input  logic                   cfg_we,
    input  logic [3:0]             cfg_idx,
    input  logic [OFF_W-1:0]       cfg_off,
`ifdef TZ_DST_EN
    input  logic [NUM_ZONES-1:0]   dst_mask,
`endif
    output logic [6*NUM_ZONES-1:0] zone_hour,
    output logic [6*NUM_ZONES-1:0] zone_min,
    output logic [2*NUM_ZONES-1:0] zone_day,
    output logic [5:0]             hour_zone,
    output logic [5:0]             min_zone,
    output logic [1:0]             day_zone,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam logic [3:0] LastIdx = 4'(NUM_ZONES - 1);

    state_t                   state_q, state_d;
    logic [3:0]               idx_q, idx_d;
    logic                     pend_q, pend_d;
    logic [5:0]               snap_hour_q, snap_hour_d;
    logic [5:0]               snap_min_q, snap_min_d;
`ifdef TZ_DST_EN
    logic [NUM_ZONES-1:0]     snap_dst_q, snap_dst_d;
`endif
    logic [OFF_W-1:0]         tbl_q [NUM_ZONES];
    logic [OFF_W-1:0]         tbl_d [NUM_ZONES];
    logic [6*NUM_ZONES-1:0]   zh_q, zh_d;
    logic [6*NUM_ZONES-1:0]   zm_q, zm_d;
    logic [2*NUM_ZONES-1:0]   zd_q, zd_d;
    logic [5:0]               sel_hour_q, sel_hour_d;
    logic [5:0]               sel_min_q, sel_min_d;
    logic [1:0]               sel_day_q, sel_day_d;
    logic                     err_q, err_d;

    logic                     snap_valid;
    logic                     sel_live;
    logic signed [ADD_OFF_W-1:0] scan_off;
    logic [5:0]               add_hour, add_min;
    day_adj_t                 add_day;
    logic [5:0]               pick_hour, pick_min;
    logic [1:0]               pick_day;
    int                       cfg_sat;

    tz_offset_add u_add (
        .hour_i (snap_hour_q),
        .min_i  (snap_min_q),
        .off_i  (scan_off),
        .hour_o (add_hour),
        .min_o  (add_min),
        .day_o  (add_day)
    );

    assign snap_valid = (snap_hour_q <= 6'd23) && (snap_min_q <= 6'd59);

    always_comb begin
        scan_off = '0;
        for (int i = 0; i < int'(NUM_ZONES); i++) begin
            if (idx_q == 4'(i)) begin
                scan_off = ADD_OFF_W'($signed(tbl_q[i]));
`ifdef TZ_DST_EN
                if (snap_dst_q[i]) scan_off = scan_off + ADD_OFF_W'(DST_QTR);
`endif
            end
        end
    end

    // Lowest set bit wins, so walk from the top down and let lower indices overwrite.
    always_comb begin
        pick_hour = snap_hour_q;
        pick_min  = snap_min_q;
        pick_day  = DaySame;
        for (int i = int'(NUM_ZONES) - 1; i >= 0; i--) begin
            if (zone_sel[i]) begin
                pick_hour = zh_q[6*i +: 6];
                pick_min  = zm_q[6*i +: 6];
                pick_day  = zd_q[2*i +: 2];
            end
        end
    end

    // Selected outputs track zone_sel live during DONE and are frozen when DONE exits.
    assign sel_live  = (state_q == StDone) && snap_valid;
    assign hour_zone = sel_live ? pick_hour : sel_hour_q;
    assign min_zone  = sel_live ? pick_min : sel_min_q;
    assign day_zone  = sel_live ? pick_day : sel_day_q;
    assign done      = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign err       = err_q;
    assign zone_hour = zh_q;
    assign zone_min  = zm_q;
    assign zone_day  = zd_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pend_d      = pend_q;
        snap_hour_d = snap_hour_q;
        snap_min_d  = snap_min_q;
`ifdef TZ_DST_EN
        snap_dst_d  = snap_dst_q;
`endif
        tbl_d       = tbl_q;
        zh_d        = zh_q;
        zm_d        = zm_q;
        zd_d        = zd_q;
        sel_hour_d  = sel_hour_q;
        sel_min_d   = sel_min_q;
        sel_day_d   = sel_day_q;
        err_d       = err_q;

        cfg_sat = sat_off(int'($signed(cfg_off)));
        for (int i = 0; i < int'(NUM_ZONES); i++) begin
            if (cfg_we && (cfg_idx == 4'(i))) tbl_d[i] = OFF_W'(cfg_sat);
        end

        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    snap_hour_d = hour_in;
                    snap_min_d  = min_in;
`ifdef TZ_DST_EN
                    snap_dst_d  = dst_mask;
`endif
                    idx_d       = 4'd0;
                    state_d     = StScan;
                end
            end
            StScan: begin
                if (tick) pend_d = 1'b1;
                if (snap_valid) begin
                    for (int i = 0; i < int'(NUM_ZONES); i++) begin
                        if (idx_q == 4'(i)) begin
                            zh_d[6*i +: 6] = add_hour;
                            zm_d[6*i +: 6] = add_min;
                            zd_d[2*i +: 2] = add_day;
                        end
                    end
                end
                if (idx_q == LastIdx) begin
                    err_d   = ~snap_valid;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            StDone: begin
                sel_hour_d = hour_zone;
                sel_min_d  = min_zone;
                sel_day_d  = day_zone;
                if (pend_q || tick) begin
                    snap_hour_d = hour_in;
                    snap_min_d  = min_in;
`ifdef TZ_DST_EN
                    snap_dst_d  = dst_mask;
`endif
                    pend_d      = 1'b0;
                    idx_d       = 4'd0;
                    state_d     = StScan;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= 4'd0;
            pend_q      <= 1'b0;
            snap_hour_q <= 6'd0;
            snap_min_q  <= 6'd0;
`ifdef TZ_DST_EN
            snap_dst_q  <= '0;
`endif
            for (int i = 0; i < int'(NUM_ZONES); i++) begin
                tbl_q[i] <= OFF_W'(default_off(i));
            end
            zh_q        <= '0;
            zm_q        <= '0;
            zd_q        <= '0;
            sel_hour_q  <= 6'd0;
            sel_min_q   <= 6'd0;
            sel_day_q   <= 2'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            snap_hour_q <= snap_hour_d;
            snap_min_q  <= snap_min_d;
`ifdef TZ_DST_EN
            snap_dst_q  <= snap_dst_d;
`endif
            tbl_q       <= tbl_d;
            zh_q        <= zh_d;
            zm_q        <= zm_d;
            zd_q        <= zd_d;
            sel_hour_q  <= sel_hour_d;
            sel_min_q   <= sel_min_d;
            sel_day_q   <= sel_day_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_tz_world_clock.sv
// Self-checking bench for tz_world_clock: directed cases plus randomized scans vs a minute-count model.
module tb_tz_world_clock;

    localparam int NZ = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            tick;
    logic [5:0]      hour_in, min_in;
    logic [NZ-1:0]   zone_sel;
    logic [NZ-1:0]   dst_mask;
    logic            cfg_we;
    logic [3:0]      cfg_idx;
    logic [7:0]      cfg_off;
    logic [6*NZ-1:0] zone_hour, zone_min;
    logic [2*NZ-1:0] zone_day;
    logic [5:0]      hour_zone, min_zone;
    logic [1:0]      day_zone;
    logic            busy, done, err;

    int n_total = 0;
    int n_bad   = 0;

    // Reference state: offsets in quarter hours, zone results, selected result, error flag.
    int m_off [NZ];
    int m_h [NZ];
    int m_m [NZ];
    int m_d [NZ];
    int m_sh, m_sm, m_sd, m_err;

    always #5 clk = ~clk;

    tz_world_clock #(
        .NUM_ZONES (NZ),
        .OFF_W     (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .hour_in   (hour_in),
        .min_in    (min_in),
        .zone_sel  (zone_sel),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_off   (cfg_off),
`ifdef TZ_DST_EN
        .dst_mask  (dst_mask),
`endif
        .zone_hour (zone_hour),
        .zone_min  (zone_min),
        .zone_day  (zone_day),
        .hour_zone (hour_zone),
        .min_zone  (min_zone),
        .day_zone  (day_zone),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        int defs [4] = '{4, 12, 24, 36};
        for (int i = 0; i < NZ; i++) begin
            m_off[i] = (i < 4) ? defs[i] : 0;
            m_h[i] = 0;
            m_m[i] = 0;
            m_d[i] = 0;
        end
        m_sh = 0;
        m_sm = 0;
        m_sd = 0;
        m_err = 0;
    endtask

    // Day code: 0 same, 1 next day, 3 previous day.
    task automatic convert(input int h, input int m, input int off,
                           output int oh, output int om, output int od);
        int t;
        t = h * 60 + m + off * 15;
        od = 0;
        if (t >= 1440) begin
            t = t - 1440;
            od = 1;
        end else if (t < 0) begin
            t = t + 1440;
            od = 3;
        end
        oh = t / 60;
        om = t % 60;
    endtask

    task automatic model_apply(input int h, input int m, input logic [NZ-1:0] sel,
                               input logic [NZ-1:0] dst);
        int adj;
        bit found;
        if (h > 23 || m > 59) begin
            m_err = 1;
            return;
        end
        for (int i = 0; i < NZ; i++) begin
            adj = 0;
`ifdef TZ_DST_EN
            if (dst[i]) adj = 4;
`endif
            convert(h, m, m_off[i] + adj, m_h[i], m_m[i], m_d[i]);
        end
        m_sh = h;
        m_sm = m;
        m_sd = 0;
        found = 0;
        for (int i = 0; i < NZ; i++) begin
            if (sel[i] && !found) begin
                found = 1;
                m_sh = m_h[i];
                m_sm = m_m[i];
                m_sd = m_d[i];
            end
        end
        m_err = 0;
    endtask

    task automatic check_sel(input string pfx);
        check({pfx, "_sel_hour"}, 32'(hour_zone), m_sh);
        check({pfx, "_sel_min"}, 32'(min_zone), m_sm);
        check({pfx, "_sel_day"}, 32'(day_zone), m_sd);
        check({pfx, "_err"}, 32'(err), m_err);
    endtask

    task automatic check_all(input string pfx);
        for (int i = 0; i < NZ; i++) begin
            check($sformatf("%s_z%0d_hour", pfx, i), 32'(zone_hour[6*i +: 6]), m_h[i]);
            check($sformatf("%s_z%0d_min", pfx, i), 32'(zone_min[6*i +: 6]), m_m[i]);
            check($sformatf("%s_z%0d_day", pfx, i), 32'(zone_day[2*i +: 2]), m_d[i]);
        end
        check_sel(pfx);
    endtask

    task automatic cfg_write(input int idx, input int off);
        @(negedge clk);
        cfg_we  = 1'b1;
        cfg_idx = 4'(idx);
        cfg_off = 8'(off);
        @(negedge clk);
        cfg_we  = 1'b0;
        if (idx < NZ) m_off[idx] = (off < -48) ? -48 : ((off > 56) ? 56 : off);
    endtask

    task automatic run_scan(input string pfx, input int h, input int m,
                            input logic [NZ-1:0] sel, input logic [NZ-1:0] dst);
        int n;
        @(negedge clk);
        tick     = 1'b1;
        hour_in  = 6'(h);
        min_in   = 6'(m);
        zone_sel = sel;
        dst_mask = dst;
        @(negedge clk);
        tick = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({pfx, "_latency"}, 32'(n), NZ + 1);
        check({pfx, "_busy_in_done"}, 32'(busy), 1);
        model_apply(h, m, sel, dst);
        check_sel(pfx);
        @(negedge clk);
        check({pfx, "_done_one_cycle"}, 32'(done), 0);
        check({pfx, "_busy_after"}, 32'(busy), 0);
        check_all(pfx);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int e1h, e1m, e2h, e2m, n_done, t1, t2;
        rst      = 1'b1;
        tick     = 1'b0;
        hour_in  = '0;
        min_in   = '0;
        zone_sel = '0;
        dst_mask = '0;
        cfg_we   = 1'b0;
        cfg_idx  = '0;
        cfg_off  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        rst = 1'b0;

        // Default table, 23:30 rolls into the next day for every zone.
        run_scan("t1", 23, 30, 4'b0001, 4'b0000);
        check("t1_z0_hour_k", 32'(zone_hour[5:0]), 0);
        check("t1_z0_day_k", 32'(zone_day[1:0]), 1);
        check("t1_z3_hour_k", 32'(zone_hour[23:18]), 8);
        check("t1_z3_min_k", 32'(zone_min[23:18]), 30);

        cfg_write(1, -20);
        run_scan("t2", 2, 10, 4'b0110, 4'b0000);
        check("t2_z1_hour_k", 32'(zone_hour[11:6]), 21);
        check("t2_z1_day_k", 32'(zone_day[3:2]), 3);

        run_scan("t3", 13, 45, 4'b0000, 4'b0000);
        check("t3_z2_hour_k", 32'(zone_hour[17:12]), 19);
        check("t3_sel_hour_k", 32'(hour_zone), 13);

        // Back-to-back: extra ticks during SCAN coalesce into one follow-up scan.
        @(negedge clk);
        tick     = 1'b1;
        hour_in  = 6'd9;
        min_in   = 6'd5;
        zone_sel = 4'b1000;
        model_apply(9, 5, 4'b1000, 4'b0000);
        e1h = m_sh;
        e1m = m_sm;
        model_apply(20, 50, 4'b1000, 4'b0000);
        e2h = m_sh;
        e2m = m_sm;
        n_done = 0;
        t1 = 0;
        t2 = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            tick = (i == 2 || i == 3);
            if (i == 2 || i == 3) hour_in = 6'(i);
            if (i == 4) begin
                hour_in = 6'd20;
                min_in  = 6'd50;
            end
            if (done === 1'b1) begin
                n_done++;
                if (n_done == 1) begin
                    t1 = i;
                    check("b2b_first_hour", 32'(hour_zone), e1h);
                    check("b2b_first_min", 32'(min_zone), e1m);
                end else begin
                    t2 = i;
                    check("b2b_second_hour", 32'(hour_zone), e2h);
                    check("b2b_second_min", 32'(min_zone), e2m);
                end
            end
        end
        check("b2b_done_count", 32'(n_done), 2);
        check("b2b_first_at", 32'(t1), NZ + 1);
        check("b2b_gap", 32'(t2 - t1), NZ + 1);
        check_all("b2b");

        run_scan("bad_hour", 24, 10, 4'b0001, 4'b0000);
        run_scan("bad_min", 3, 60, 4'b0010, 4'b0000);
        run_scan("recover", 7, 5, 4'b0100, 4'b0000);

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0)
                cfg_write(int'($urandom_range(0, NZ + 3)), int'($urandom_range(0, 255)) - 128);
            run_scan($sformatf("rnd%0d", k), int'($urandom_range(0, 24)),
                     int'($urandom_range(0, 61)), NZ'($urandom), NZ'($urandom));
        end

        // Reset at scan index 2 with a tick pending: no done, table back to defaults.
        @(negedge clk);
        tick     = 1'b1;
        hour_in  = 6'd5;
        min_in   = 6'd0;
        zone_sel = 4'b0001;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        rst  = 1'b1;
        #1;
        model_reset();
        check_all("midrst");
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        check("midrst_no_done", 32'(n_done), 0);
        check("midrst_busy_after", 32'(busy), 0);
        run_scan("post_rst", 18, 20, 4'b0010, 4'b0000);

`ifdef TZ_DST_EN
        run_scan("dst", 10, 0, 4'b0001, 4'b0001);
        check("dst_z0_hour_k", 32'(zone_hour[5:0]), 12);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
